// File: rtl/aes_decrypt_round_ctrl.sv
// AES-128 decryption round sequencer.
// Drives the inverse key expander (decipher_new_en / round_key_en / round_num)
// and the inverse-round datapath (dp_load / dp_round_en / dp_final) for one
// ciphertext block. The block steps through IDLE -> LOAD -> ROUND x(NR-1) ->
// FINAL -> DONE, with datapath stall, synchronous abort and result backpressure.
//
// Handshake rules, used on both the request and the result side: a transfer
// happens on the rising edge where valid && ready are both high. The producer
// holds valid and its payload stable until that edge. ready may depend
// combinationally on the consumer's own state but never on valid. start_ready
// depends on key10_valid and abort, not on start_valid. out_valid comes from
// state only and stays high until out_ready is seen or an abort discards it.
//
// NR must stay at 10 while the attached key expander only handles AES-128.
// RW must be wide enough to hold NR (2**RW > NR).
module aes_decrypt_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic          key10_valid,
  input  logic          stall,
  input  logic          abort,
  output logic          decipher_new_en,
  output logic          round_key_en,
  output logic [RW-1:0] round_num,
  output logic          dp_load,
  output logic          dp_round_en,
  output logic          dp_final,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RW-1:0] LP_LAST_ROUND = RW'(NR - 1);
  localparam logic [RW-1:0] LP_NR         = RW'(NR);

  state_t        r_state;
  logic [RW-1:0] r_rcnt;
  logic          w_accept;
  logic          w_advance;

  // A request is taken when the requester is valid and the controller is ready.
  assign w_accept = start_valid && start_ready;

  // Enables fire only when the datapath can advance and nothing cancels the cycle.
  assign w_advance = !stall && !abort;

  // Sequencer: state and round counter. Abort wins over every other event,
  // including stall and out_ready. Stall is ignored in IDLE and DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
    end else if (r_state != S_IDLE && abort) begin
      r_state <= S_IDLE;
      r_rcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_LOAD;
            r_rcnt  <= '0;
          end
        end
        S_LOAD: begin
          if (!stall) begin
            r_state <= S_ROUND;
            r_rcnt  <= RW'(1);
          end
        end
        S_ROUND: begin
          if (!stall) begin
            r_rcnt <= r_rcnt + 1'b1;
            if (r_rcnt == LP_LAST_ROUND) begin
              r_state <= S_FINAL;
            end
          end
        end
        S_FINAL: begin
          if (!stall) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
            r_rcnt  <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rcnt  <= '0;
        end
      endcase
    end
  end

  // Output decode from the registered state. round_num is 0 outside ROUND and
  // FINAL. start_ready is also held low while reset is asserted, so no output
  // rises during reset even if key10_valid is already high.
  always_comb begin
    start_ready     = 1'b0;
    decipher_new_en = 1'b0;
    round_key_en    = 1'b0;
    round_num       = '0;
    dp_load         = 1'b0;
    dp_round_en     = 1'b0;
    dp_final        = 1'b0;
    out_valid       = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = key10_valid && !abort && reset_n;
      end
      S_LOAD: begin
        decipher_new_en = w_advance;
        dp_load         = w_advance;
      end
      S_ROUND: begin
        round_num    = r_rcnt;
        round_key_en = w_advance;
        dp_round_en  = w_advance;
      end
      S_FINAL: begin
        round_num = LP_NR;
        dp_final  = w_advance;
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        start_ready = 1'b0;
      end
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  // The key expander must never be loaded and advanced in the same cycle.
  a_key_ctrl_exclusive : assert property (
    @(posedge clk) disable iff (!reset_n) !(decipher_new_en && round_key_en)
  );

endmodule
